// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, x/y raster counters, registered blanking/sync/strobes.
// Optional 16-bit frame counter is built only when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CNT_W     = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable,
  output logic             p_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = 5;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             HS_ON    = 1'(HSYNC_POL);
  localparam logic             VS_ON    = 1'(VSYNC_POL);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] x_nxt_s, y_nxt_s;
  logic             video_on_q, video_on_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  assign p_tick = enable && (div_q == DIV_LAST);

  // Raster position the next pixel tick moves to
  always_comb begin
    x_nxt_s = x_q + CNT_W'(1);
    y_nxt_s = y_q;
    if (x_q == H_LAST) begin
      x_nxt_s = '0;
      if (y_q == V_LAST) begin
        y_nxt_s = '0;
      end else begin
        y_nxt_s = y_q + CNT_W'(1);
      end
    end else begin
      y_nxt_s = y_q;
    end
  end

  // Divider and registered outputs; outputs are decoded from the next position so they align with x/y
  always_comb begin
    div_d         = div_q;
    x_d           = x_q;
    y_d           = y_q;
    video_on_d    = video_on_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end else begin
      div_d = div_q;
    end
    if (p_tick) begin
      x_d           = x_nxt_s;
      y_d           = y_nxt_s;
      video_on_d    = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
      hsync_d       = ((x_nxt_s >= HS_FIRST) && (x_nxt_s <= HS_LAST)) ? HS_ON : ~HS_ON;
      vsync_d       = ((y_nxt_s >= VS_FIRST) && (y_nxt_s <= VS_LAST)) ? VS_ON : ~VS_ON;
      line_start_d  = (x_nxt_s == '0);
      frame_start_d = (x_nxt_s == '0) && (y_nxt_s == '0);
    end else begin
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  // State registers; reset parks the raster on the last position so the first tick lands on (0,0)
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      video_on_q    <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      video_on_q    <= video_on_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Frame counter advances on the edge that raises frame_start
  always_comb begin
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame counter register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      frame_count_q <= 16'h0000;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a 640x480 default instance and a tiny 7x7 CLK_DIV=1 instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-mode instance
  logic        reset_a, enable_a, p_tick_a, von_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0]  x_a, y_a;
  logic [15:0] fc_a;

  // tiny-mode instance
  logic        reset_b, enable_b, p_tick_b, von_b, hs_b, vs_b, ls_b, fs_b;
  logic [3:0]  x_b, y_b;
  logic [15:0] fc_b;

  vga_timing_gen dut_a (
    .clk_100MHz(clk), .reset(reset_a), .enable(enable_a), .p_tick(p_tick_a),
    .x(x_a), .y(y_a), .video_on(von_a), .hsync(hs_a), .vsync(vs_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HSYNC_POL(1), .VSYNC_POL(1), .CNT_W(4)
  ) dut_b (
    .clk_100MHz(clk), .reset(reset_b), .enable(enable_b), .p_tick(p_tick_b),
    .x(x_b), .y(y_b), .video_on(von_b), .hsync(hs_b), .vsync(vs_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  int   errors = 0;
  int   checks = 0;
  obs_t qa[$];
  obs_t qb[$];
  int   idx_a = 0, frames_a = 0, idx_b = 0, frames_b = 0;

  localparam obs_t RST_A = '{x: 10'd799, y: 10'd524, von: 1'b0, hs: 1'b1, vs: 1'b1,
                             ls: 1'b0, fs: 1'b0, fc: 16'h0000};
  localparam obs_t RST_B = '{x: 10'd6, y: 10'd6, von: 1'b0, hs: 1'b0, vs: 1'b0,
                             ls: 1'b0, fs: 1'b0, fc: 16'h0000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t obs_a();
    return {x_a, y_a, von_a, hs_a, vs_a, ls_a, fs_a, fc_a};
  endfunction

  function automatic obs_t obs_b();
    return {6'd0, x_b, 6'd0, y_b, von_b, hs_b, vs_b, ls_b, fs_b, fc_b};
  endfunction

  // expected raster for 640x480: total 800x525, hsync low x=656..751, vsync low y=490..491
  task automatic push_a(input int n);
    obs_t e;
    int   px, py;
    for (int i = 0; i < n; i++) begin
      px    = idx_a % 800;
      py    = (idx_a / 800) % 525;
      e.x   = 10'(px);
      e.y   = 10'(py);
      e.von = (px < 640) && (py < 480);
      e.hs  = !((px >= 656) && (px <= 751));
      e.vs  = !((py >= 490) && (py <= 491));
      e.ls  = (px == 0);
      e.fs  = (px == 0) && (py == 0);
      if (e.fs) frames_a++;
      e.fc  = FC_EN ? frames_a[15:0] : 16'h0000;
      qa.push_back(e);
      idx_a++;
    end
  endtask

  // expected raster for 7x7 mode: sync pulses are active-high at x=5 / y=5
  task automatic push_b(input int n);
    obs_t e;
    int   px, py;
    for (int i = 0; i < n; i++) begin
      px    = idx_b % 7;
      py    = (idx_b / 7) % 7;
      e.x   = 10'(px);
      e.y   = 10'(py);
      e.von = (px < 4) && (py < 4);
      e.hs  = (px == 5);
      e.vs  = (py == 5);
      e.ls  = (px == 0);
      e.fs  = (px == 0) && (py == 0);
      if (e.fs) frames_b++;
      e.fc  = FC_EN ? frames_b[15:0] : 16'h0000;
      qb.push_back(e);
      idx_b++;
    end
  endtask

  // monitor A: after a sampled p_tick pop and compare; otherwise everything must hold with strobes low
  obs_t hold_a;
  bit   pend_a = 1'b0;
  always @(negedge clk) begin
    obs_t o, e;
    o = obs_a();
    if (reset_a) begin
      pend_a = 1'b0;
      hold_a = RST_A;
    end else begin
      if (pend_a) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_tick", 64'(o), 64'(hold_a));
        end else begin
          e = qa.pop_front();
          chk("a_tick", 64'(o), 64'(e));
          hold_a = e;
        end
      end else begin
        e    = hold_a;
        e.ls = 1'b0;
        e.fs = 1'b0;
        chk("a_hold", 64'(o), 64'(e));
      end
      if (!enable_a) chk("a_ptick_disabled", 64'(p_tick_a), 64'd0);
      pend_a = p_tick_a;
    end
  end

  // monitor B: same discipline for the tiny-mode instance
  obs_t hold_b;
  bit   pend_b = 1'b0;
  always @(negedge clk) begin
    obs_t o, e;
    o = obs_b();
    if (reset_b) begin
      pend_b = 1'b0;
      hold_b = RST_B;
    end else begin
      if (pend_b) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_tick", 64'(o), 64'(hold_b));
        end else begin
          e = qb.pop_front();
          chk("b_tick", 64'(o), 64'(e));
          hold_b = e;
        end
      end else begin
        e    = hold_b;
        e.ls = 1'b0;
        e.fs = 1'b0;
        chk("b_hold", 64'(o), 64'(e));
      end
      if (!enable_b) chk("b_ptick_disabled", 64'(p_tick_b), 64'd0);
      pend_b = p_tick_b;
    end
  end

  initial begin
    int t_first, t_301, t_ls1, t_ls2, t_fs1, t_fs2, t_fs3;
    reset_a  = 1'b1;
    enable_a = 1'b1;
    reset_b  = 1'b1;
    enable_b = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("a_reset_values", 64'(obs_a()), 64'(RST_A));
    chk("a_reset_ptick", 64'(p_tick_a), 64'd0);

    // default mode: release, first tick on the 4th edge lands on (0,0)
    push_a(301);
    reset_a = 1'b0;
    t_first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #2;
      if (t_first == 0 && x_a == 10'd0 && y_a == 10'd0) t_first = i;
    end
    chk("a_first_tick_edge", 64'(t_first), 64'd4);

    // reach x=300, go two divider cycles in, then freeze for 37 cycles
    repeat (1198) @(posedge clk);
    #2;
    chk("a_x_before_pause", 64'(x_a), 64'd300);
    enable_a = 1'b0;
    push_a(1400);
    repeat (37) @(posedge clk);
    #2;
    chk("a_x_after_pause", 64'(x_a), 64'd300);
    enable_a = 1'b1;
    t_301 = 0;
    t_ls1 = 0;
    t_ls2 = 0;
    for (int i = 1; i <= 5599; i++) begin
      @(posedge clk);
      #2;
      if (t_301 == 0 && x_a == 10'd301) t_301 = i;
      if (ls_a) begin
        if (t_ls1 == 0) t_ls1 = i;
        else if (t_ls2 == 0) t_ls2 = i;
      end
    end
    chk("a_resume_latency", 64'(t_301), 64'd2);
    chk("a_first_ls_after_resume", 64'(t_ls1), 64'd1998);
    chk("a_line_period", 64'(t_ls2 - t_ls1), 64'd3200);

    // async reset mid-line at (100,2)
    chk("a_pos_before_reset", 64'({x_a, y_a}), 64'({10'd100, 10'd2}));
    reset_a = 1'b1;
    #1;
    chk("a_reset_midline", 64'(obs_a()), 64'(RST_A));
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    idx_a    = 0;
    frames_a = 0;
    push_a(10);
    repeat (3) @(posedge clk);
    #2;
    reset_a = 1'b0;
    repeat (41) @(posedge clk);
    #2;
    enable_a = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // tiny mode: tick every cycle, three frames plus a little
    chk("b_reset_values", 64'(obs_b()), 64'(RST_B));
    push_b(150);
    reset_b = 1'b0;
    t_fs1 = 0;
    t_fs2 = 0;
    t_fs3 = 0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk);
      #2;
      if (fs_b) begin
        if (t_fs1 == 0) t_fs1 = i;
        else if (t_fs2 == 0) t_fs2 = i;
        else if (t_fs3 == 0) t_fs3 = i;
      end
    end
    enable_b = 1'b0;
    chk("b_first_fs_edge", 64'(t_fs1), 64'd1);
    chk("b_frame_period", 64'(t_fs2 - t_fs1), 64'd49);
    chk("b_frame_period2", 64'(t_fs3 - t_fs2), 64'd49);
    repeat (5) @(posedge clk);
    #2;
    enable_b = 1'b1;
    push_b(17);
    repeat (17) @(posedge clk);
    #2;
    enable_b = 1'b0;
    chk("b_pos_before_reset", 64'({x_b, y_b}), 64'({4'd5, 4'd2}));
    repeat (1) @(posedge clk);
    #2;
    reset_b = 1'b1;
    #1;
    chk("b_reset_midframe", 64'(obs_b()), 64'(RST_B));
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    enable_b = 1'b1;
    idx_b    = 0;
    frames_b = 0;
    push_b(10);
    repeat (3) @(posedge clk);
    #2;
    reset_b = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    enable_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    chk("a_queue_final", 64'(qa.size()), 64'd0);
    chk("b_queue_final", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the Basys 3 display path: divides the 100 MHz system clock to a pixel tick and produces pixel coordinates, blanking and sync for any mode expressible as display / front porch / sync / back porch intervals. Defaults give 640x480@60. Sync polarity and clock divide are configurable. It also provides pixel-enable gating plus line/frame start strobes. It feeds the pixel generators and the VGA pins on the same clock domain.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BACK, 48, horizontal back porch (ticks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk_100MHz cycles per pixel tick; 1..16
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CNT_W, 10, counter width; 2^CNT_W ≥ H_TOTAL and ≥ V_TOTAL

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  1 = run; 0 = freeze divider and raster
- p_tick  out  1  pixel tick, one clk_100MHz cycle wide
- x  out  CNT_W  horizontal count, 0..H_TOTAL-1
- y  out  CNT_W  vertical count, 0..V_TOTAL-1
- video_on  out  1  (x < H_DISPLAY) && (y < V_DISPLAY)
- hsync  out  1  horizontal sync at HSYNC_POL level when active
- vsync  out  1  vertical sync at VSYNC_POL level when active
- line_start  out  1  one-cycle strobe when x enters 0
- frame_start  out  1  one-cycle strobe when (x,y) enters (0,0)
- frame_count  out  16  frame counter (see Configuration)

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Line order is display, front porch, sync, back porch.
- Divider:
  - div counts 0..CLK_DIV-1 while enable=1 and wraps to 0.
  - p_tick = enable && (div == CLK_DIV-1). With CLK_DIV=1, p_tick = enable.
- On each p_tick:
  - x increments. At H_TOTAL-1, x wraps to 0 and y increments.
  - y wraps to 0 after V_TOTAL-1 when x also wraps.
- hsync is active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
- vsync is active for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
- video_on, hsync, vsync, line_start and frame_start are registered. Each is computed from the next counter values and loaded on the same edge as x/y, so it always matches the current (x,y).
- line_start and frame_start are high for exactly one clk_100MHz cycle, the first cycle of the new position, regardless of CLK_DIV.
- enable=0: div, x, y, video_on and sync outputs hold; p_tick and strobes are 0. Resuming continues from the held div value.
- Reset (async, any time, including mid-line):
  - div=0, x=H_TOTAL-1, y=V_TOTAL-1.
  - video_on=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - line_start=frame_start=0, frame_count=0.
  - The first p_tick after release moves to (0,0) and pulses line_start and frame_start together.
- All arithmetic is unsigned CNT_W. No counter value ≥ H_TOTAL or V_TOTAL ever appears.

## Timing
- p_tick latency: the first p_tick occurs CLK_DIV cycles after reset release with enable=1, i.e. on the CLK_DIV-th rising edge.
- Output update: the x/y/video_on/sync/strobes change on the rising edge at which p_tick is sampled high.
- Line period: H_TOTAL × CLK_DIV clk cycles (defaults: 3200). Frame period: V_TOTAL lines (defaults: 525 lines, 1,680,000 cycles).
- Simultaneous x and y wrap: frame_start and line_start assert on the same cycle.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - frame_count is a 16-bit register, incremented on the same edge that asserts frame_start.
  - It wraps 0xFFFF→0 and is cleared by reset.
  - It holds while enable=0.
- Macro undefined: frame_count is tied to 16'h0000 and no register is built. The port is present in both builds.

## Test plan
- Reset then release, defaults, enable=1:
  - x=799, y=524, video_on=0, hsync=vsync=1 during reset.
  - First p_tick on the 4th edge; (x,y)=(0,0), video_on=1, line_start=frame_start=1 for one cycle.
- One full line at defaults:
  - hsync=0 exactly for x=656..751 (96 ticks).
  - video_on=0 from x=640.
  - line_start interval is 3200 cycles.
- One full frame at defaults:
  - vsync=0 exactly for y=490..491.
  - frame_start interval is 1,680,000 cycles.
  - With the macro defined, frame_count increments by 1 per frame.
- enable=0 for 37 cycles mid-line at x=300:
  - x, y and outputs hold; no p_tick.
  - On resume, x=301 arrives after the remaining divider cycles.
- CLK_DIV=1, all porch/sync parameters 1, H_DISPLAY=V_DISPLAY=4, HSYNC_POL=VSYNC_POL=1:
  - H_TOTAL=7 and V_TOTAL=7; x steps every cycle.
  - hsync=1 only at x=5.
  - line_start and frame_start are still single-cycle.
- Async reset asserted mid-frame at (x,y)=(123,45):
  - Outputs go immediately to reset values.
  - After release, the raster restarts at (0,0) with frame_start.
  - frame_count=0, then 1 after that first frame_start (macro defined).
